data_postprocessing: RTL and testbench

- Output-side counterpart of the input preprocessing stage in the conv AXI datapath.
- Takes signed accumulator results from the conv MAC/kernel array and requantizes them to DATA_BW.
  - Rounding arithmetic right shift, then saturation.
- Presents each result on a valid/ready output stream toward the AXI write/stream master, with a per-frame last flag.
- Two-stage register pipeline with full backpressure.

---
 rtl/data_postprocessing_pkg.sv | 21 ++
 rtl/data_postprocessing_requant_sat.sv | 33 +++
 rtl/data_postprocessing.sv | 88 ++++++++
 tb/tb_data_postprocessing.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_postprocessing_pkg.sv
// Shared conv-datapath definitions: default widths, saturation bounds and the
// widened accumulator type used between rounding shift and saturation.
package data_postprocessing_pkg;

    localparam int DATA_BW_DEF = 8;
    localparam int ACC_BW_DEF  = 20;
    localparam int SAT_MAX     = (1 <<< (DATA_BW_DEF - 1)) - 1;
    localparam int SAT_MIN     = -(1 <<< (DATA_BW_DEF - 1));

    // One guard bit above the accumulator so the rounding add cannot wrap
    typedef logic signed [ACC_BW_DEF:0] acc_ext_t;

    function automatic int sat_hi(input int bw);
        return (1 <<< (bw - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int bw);
        return -(1 <<< (bw - 1));
    endfunction

endpackage

// File: rtl/data_postprocessing_requant_sat.sv
// Combinational saturation of the widened, rounded accumulator to DATA_BW.
// With DATA_POSTPROC_RELU_EN defined, negative results are clamped to zero.
module data_postprocessing_requant_sat
    import data_postprocessing_pkg::*;
#(
    parameter int DATA_BW = DATA_BW_DEF,
    parameter int ACC_BW  = ACC_BW_DEF,
    parameter int HI      = SAT_MAX,
    parameter int LO      = SAT_MIN
) (
    input  logic signed [ACC_BW:0]    r,
    output logic signed [DATA_BW-1:0] y
);

    localparam logic signed [ACC_BW:0] HI_X = (ACC_BW + 1)'(HI);
    localparam logic signed [ACC_BW:0] LO_X = (ACC_BW + 1)'(LO);

    always_comb begin
        if (r > HI_X) begin
            y = DATA_BW'(HI);
        end else if (r < LO_X) begin
            y = DATA_BW'(LO);
        end else begin
            y = r[DATA_BW-1:0];
        end
`ifdef DATA_POSTPROC_RELU_EN
        if (r[ACC_BW]) begin
            y = '0;
        end
`endif
    end

endmodule

// File: rtl/data_postprocessing.sv
// Requantizing output stage: rounding arithmetic shift, saturation, 2-deep
// valid/ready pipeline with per-frame last flag. Optional ReLU: DATA_POSTPROC_RELU_EN.
module data_postprocessing
    import data_postprocessing_pkg::*;
#(
    parameter int DATA_BW   = DATA_BW_DEF,
    parameter int ACC_BW    = ACC_BW_DEF,
    parameter int SHIFT_BW  = 5,
    parameter int FRAME_LEN = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [ACC_BW-1:0]  i_acc,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [SHIFT_BW-1:0]       i_shift,
    output logic signed [DATA_BW-1:0] o_y,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_last
);

    localparam int               CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic                      adv;
    logic                      v1;
    logic signed [ACC_BW:0]    r1;
    logic signed [ACC_BW:0]    acc_ext;
    logic signed [ACC_BW:0]    rnd;
    logic signed [ACC_BW:0]    sum;
    logic signed [ACC_BW:0]    r_next;
    logic signed [DATA_BW-1:0] y_sat;
    logic [CNT_W-1:0]          cnt;

    // Whole pipeline moves as one; a bubble in stage 1 never blocks stage 2
    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    always_comb begin
        acc_ext = {i_acc[ACC_BW-1], i_acc};
        rnd     = '0;
        if (i_shift != '0) begin
            rnd = (ACC_BW + 1)'(1) << (i_shift - 1'b1);
        end
        sum    = acc_ext + rnd;
        r_next = sum >>> i_shift;
    end

    data_postprocessing_requant_sat #(
        .DATA_BW (DATA_BW),
        .ACC_BW  (ACC_BW),
        .HI      (sat_hi(DATA_BW)),
        .LO      (sat_lo(DATA_BW))
    ) u_requant_sat (
        .r (r1),
        .y (y_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            r1      <= '0;
            o_valid <= 1'b0;
            o_y     <= '0;
        end else if (adv) begin
            v1      <= i_valid;
            r1      <= r_next;
            o_valid <= v1;
            o_y     <= y_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (o_valid && i_ready) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_last = o_valid && (cnt == CNT_LAST);

endmodule

// File: tb/tb_data_postprocessing.sv
// Directed bench for data_postprocessing: vector table for rounding/saturation,
// plus streaming sequences for backpressure, last flag, reset and throughput.
module tb_data_postprocessing;

    localparam int DATA_BW   = 8;
    localparam int ACC_BW    = 20;
    localparam int SHIFT_BW  = 5;
    localparam int FRAME_LEN = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic signed [ACC_BW-1:0]  i_acc;
    logic                      i_valid;
    logic                      o_ready;
    logic [SHIFT_BW-1:0]       i_shift;
    logic signed [DATA_BW-1:0] o_y;
    logic                      o_valid;
    logic                      i_ready;
    logic                      o_last;

    int checks   = 0;
    int failures = 0;

    int out_y[$];
    int out_last[$];
    int out_cyc[$];

    typedef struct {
        int acc;
        int sh;
        int y;
    } vec_t;

    vec_t vecs[16];

    data_postprocessing #(
        .DATA_BW   (DATA_BW),
        .ACC_BW    (ACC_BW),
        .SHIFT_BW  (SHIFT_BW),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_acc   (i_acc),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_shift (i_shift),
        .o_y     (o_y),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_last  (o_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_acc   = '0;
        i_shift = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Streams values 1..n at shift 0; optional input bubbles every gap cycles,
    // optional i_ready stall of `stall` cycles once the first o_valid appears.
    task automatic stream(input int n, input int gap, input int stall);
        int  sent       = 0;
        int  got        = 0;
        int  cyc        = 0;
        int  stall_left = 0;
        bit  stalled    = 1'b0;
        out_y.delete();
        out_last.delete();
        out_cyc.delete();
        i_shift = '0;
        while (got < n && cyc < 200) begin
            if (sent < n && !(gap != 0 && (cyc % gap) == gap - 1)) begin
                i_valid = 1'b1;
                i_acc   = ACC_BW'(sent + 1);
            end else begin
                i_valid = 1'b0;
            end
            if (!stalled && stall > 0 && o_valid) begin
                stalled    = 1'b1;
                stall_left = stall;
            end
            i_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                chk("stall_o_ready", int'(o_ready), 0);
                chk("stall_o_valid", int'(o_valid), 1);
                chk("stall_o_y_hold", int'(o_y), got + 1);
                stall_left--;
            end else begin
                chk("o_ready_high", int'(o_ready), 1);
            end
            if (i_valid && o_ready) sent++;
            if (o_valid && i_ready) begin
                out_y.push_back(int'(o_y));
                out_last.push_back(int'(o_last));
                out_cyc.push_back(cyc);
                got++;
            end
            tick();
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        if (got < n) begin
            chk("stream_timeout_beats", got, n);
        end
    endtask

    task automatic chk_outputs(input string tag, input int n);
        for (int k = 0; k < n && k < out_y.size(); k++) begin
            chk({tag, "_y"}, out_y[k], k + 1);
            chk({tag, "_last"}, out_last[k], ((k + 1) % FRAME_LEN == 0) ? 1 : 0);
        end
        chk({tag, "_count"}, out_y.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp;

        vecs[0]  = '{300,      2,   75};
        vecs[1]  = '{-6,       2,   -1};
        vecs[2]  = '{5,        0,    5};
        vecs[3]  = '{100000,   4,  127};
        vecs[4]  = '{-100000,  4, -128};
        vecs[5]  = '{7,        1,    4};
        vecs[6]  = '{-7,       1,   -3};
        vecs[7]  = '{-5,       1,   -2};
        vecs[8]  = '{2040,     4,  127};
        vecs[9]  = '{2023,     4,  126};
        vecs[10] = '{-2056,    4, -128};
        vecs[11] = '{524287,  19,    1};
        vecs[12] = '{-524288, 19,   -1};
        vecs[13] = '{128,      0,  127};
        vecs[14] = '{-129,     0, -128};
        vecs[15] = '{-1,       0,   -1};

        do_reset();
        chk("reset_o_valid", int'(o_valid), 0);
        chk("reset_o_y", int'(o_y), 0);
        chk("reset_o_last", int'(o_last), 0);
        chk("reset_o_ready", int'(o_ready), 1);

        // Single beats: result must appear exactly two clocks after acceptance
        foreach (vecs[i]) begin
            exp = vecs[i].y;
`ifdef DATA_POSTPROC_RELU_EN
            if (exp < 0) exp = 0;
`endif
            i_acc   = ACC_BW'(vecs[i].acc);
            i_shift = SHIFT_BW'(vecs[i].sh);
            i_valid = 1'b1;
            #1;
            chk("vec_o_ready", int'(o_ready), 1);
            tick();
            i_valid = 1'b0;
            chk("vec_lat1_o_valid", int'(o_valid), 0);
            tick();
            chk("vec_lat2_o_valid", int'(o_valid), 1);
            chk($sformatf("vec%0d_o_y", i), int'(o_y), exp);
            tick();
            chk("vec_drain_o_valid", int'(o_valid), 0);
        end

        // Backpressure: 1,2,3 with a 5-cycle stall after first o_valid
        do_reset();
        stream(3, 0, 5);
        chk_outputs("bp", 3);

        // Last flag on beats 4 and 8, back-to-back then with input bubbles
        do_reset();
        stream(8, 0, 0);
        chk_outputs("last", 8);
        do_reset();
        stream(8, 3, 0);
        chk_outputs("last_gap", 8);

        // Reset with two beats in flight after the counter has advanced
        do_reset();
        stream(2, 0, 0);
        i_shift = '0;
        i_acc   = ACC_BW'(77);
        i_valid = 1'b1;
        tick();
        i_acc = ACC_BW'(78);
        tick();
        i_valid = 1'b0;
        chk("inflight_o_valid", int'(o_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_o_valid", int'(o_valid), 0);
        chk("rst_async_o_last", int'(o_last), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_release_o_ready", int'(o_ready), 1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst_no_stale_o_valid", int'(o_valid), 0);
        end
        stream(4, 0, 0);
        chk_outputs("rst_frame", 4);

        // Full throughput: 16 outputs on consecutive cycles
        do_reset();
        stream(16, 0, 0);
        chk_outputs("thru", 16);
        if (out_cyc.size() == 16) begin
            chk("thru_consecutive", out_cyc[15] - out_cyc[0], 15);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
